// File: rtl/otp_decoder_pkg.sv
// Shared constants for both ends of the one-time-pad link.
// The encrypt-side shifter and this decoder must use the same keystream definition.
package otp_decoder_pkg;

  localparam int unsigned MSG_SIZE = 32;
  localparam int unsigned KEY_SIZE = 8;
  localparam int unsigned LFSR_W   = 32;

  localparam int unsigned LFSR_TAP_A = 31;
  localparam int unsigned LFSR_TAP_B = 21;
  localparam int unsigned LFSR_TAP_C = 1;
  localparam int unsigned LFSR_TAP_D = 0;

  // An all-zero LFSR would lock up, so a zero seed is swapped for this value.
  localparam logic [LFSR_W-1:0] LFSR_ZERO_SEED = LFSR_W'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic fb;
    fb = s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D];
    return {s[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/otp_keystream_lfsr.sv
// Fibonacci LFSR keystream generator; steps once per advance pulse, reseeds on load.
// Shared by the encrypt and decrypt ends so both produce the same chunk sequence.
module otp_keystream_lfsr
  import otp_decoder_pkg::*;
#(
  parameter int unsigned KEY_W = KEY_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              advance,
  output logic [KEY_W-1:0]  key
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == '0) ? LFSR_ZERO_SEED : seed;
    end else if (advance) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign key = lfsr_q[KEY_W-1:0];

endmodule

// File: rtl/otp_decoder.sv
// One-time-pad receive end: XORs ciphertext beats with the regenerated keystream
// and packs them MSB-first into a single registered plaintext word.
module otp_decoder
  import otp_decoder_pkg::*;
#(
  parameter int unsigned MSG_SIZE = otp_decoder_pkg::MSG_SIZE,
  parameter int unsigned KEY_SIZE = otp_decoder_pkg::KEY_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [LFSR_W-1:0]   seed,
  input  logic                in_valid,
  input  logic [KEY_SIZE-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [MSG_SIZE-1:0] out_msg,
  input  logic                out_ready,
  output logic                busy,
  output logic [15:0]         word_count
);

  localparam int unsigned BEATS = MSG_SIZE / KEY_SIZE;
  localparam int unsigned ACC_W = MSG_SIZE - KEY_SIZE;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [1:0]          state_q,      state_d;
  logic [CNT_W-1:0]    beat_cnt_q,   beat_cnt_d;
  logic [ACC_W-1:0]    acc_q,        acc_d;
  logic [MSG_SIZE-1:0] out_msg_q,    out_msg_d;
  logic [15:0]         word_count_q, word_count_d;

  logic                accept;
  logic [KEY_SIZE-1:0] key_chunk;
  logic [KEY_SIZE-1:0] plain;

  // load has priority over an offered beat, so the keystream never steps on a reseed cycle.
  assign accept = in_valid && (state_q == ST_COLLECT) && !load;
  assign plain  = in_data ^ key_chunk;

  otp_keystream_lfsr #(
    .KEY_W (KEY_SIZE)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .seed    (seed),
    .advance (accept),
    .key     (key_chunk)
  );

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    acc_d        = acc_q;
    out_msg_d    = out_msg_q;
    word_count_d = word_count_q;

    if (load) begin
      // Stale partial beats in acc_q are shifted out by the next word.
      state_d    = ST_COLLECT;
      beat_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_COLLECT: begin
          if (accept) begin
            acc_d = ACC_W'({acc_q, plain});
            if (beat_cnt_q == LAST_BEAT) begin
              beat_cnt_d = '0;
              out_msg_d  = {acc_q, plain};
              state_d    = ST_HOLD;
            end else begin
              beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_d      = ST_COLLECT;
            word_count_d = word_count_q + 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      acc_q        <= '0;
      out_msg_q    <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      acc_q        <= acc_d;
      out_msg_q    <= out_msg_d;
      word_count_q <= word_count_d;
    end
  end

  assign in_ready   = (state_q == ST_COLLECT);
  assign out_valid  = (state_q == ST_HOLD);
  assign out_msg    = out_msg_q;
  assign busy       = (beat_cnt_q != '0);
  assign word_count = word_count_q;

endmodule

// File: tb/tb_otp_decoder.sv
// Self-checking bench for otp_decoder: table vectors, directed corner sequences,
// and randomized words against a behavioural keystream model.
module tb_otp_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] seed;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_msg;
  logic        out_ready;
  logic        busy;
  logic [15:0] word_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_lfsr;
  logic [15:0] exp_wc;
  logic [31:0] last_exp;

  typedef struct packed {
    logic [31:0] seed;
    logic [31:0] cipher;
    logic [31:0] msg;
  } vec_t;

  vec_t vecs [4];

  otp_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .seed       (seed),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_msg    (out_msg),
    .out_ready  (out_ready),
    .busy       (busy),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Keystream model: shift left by one, feed back the XOR of bits 31, 21, 1, 0.
  function automatic logic [31:0] model_step(input logic [31:0] s);
    logic [31:0] fb;
    fb = ((s >> 31) ^ (s >> 21) ^ (s >> 1) ^ s) & 32'd1;
    return (s << 1) | fb;
  endfunction

  task automatic model_load(input logic [31:0] s);
    m_lfsr = (s == 32'd0) ? 32'd1 : s;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] s);
    load = 1'b1;
    seed = s;
    tick();
    load = 1'b0;
    seed = $urandom;
    model_load(s);
  endtask

  task automatic send_beat(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("beat_accept_timeout", 64'd0, 64'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] cipher, input int gap);
    logic [31:0] exp;
    logic [7:0]  b;
    exp = 32'd0;
    for (int k = 0; k < 4; k++) begin
      b   = cipher[31-8*k -: 8];
      exp = (exp << 8) | {24'd0, b ^ m_lfsr[7:0]};
      m_lfsr = model_step(m_lfsr);
      if (k == 3) check("out_valid_before_last", out_valid, 1'b0);
      send_beat(b);
      if (k < 3) repeat (gap) tick();
    end
    last_exp = exp;
    check("out_valid_after_last", out_valid, 1'b1);
    check("out_msg_model", out_msg, exp);
  endtask

  task automatic consume(input int delay);
    for (int i = 0; i < delay; i++) begin
      tick();
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_out_msg", out_msg, last_exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_wc = exp_wc + 16'd1;
    check("out_valid_after_consume", out_valid, 1'b0);
    check("word_count", word_count, exp_wc);
  endtask

  initial begin
    vecs[0] = '{seed: 32'hABCDEF01, cipher: 32'hAACFEA0A, msg: 32'hABCDEF01};
    vecs[1] = '{seed: 32'hABCDEF01, cipher: 32'h00000000, msg: 32'h0102050B};
    vecs[2] = '{seed: 32'h00000000, cipher: 32'h00000000, msg: 32'h0103060D};
    vecs[3] = '{seed: 32'hFFFFFFFF, cipher: 32'hFFFFFFFF, msg: 32'h00010204};

    rst = 1'b1; load = 1'b0; seed = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    exp_wc = 16'd0; m_lfsr = 32'd0; last_exp = 32'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_msg", out_msg, 32'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_word_count", word_count, 16'd0);

    // IDLE ignores beats until seeded.
    in_valid = 1'b1; in_data = 8'h5A;
    repeat (3) begin
      tick();
      check("idle_in_ready", in_ready, 1'b0);
      check("idle_busy", busy, 1'b0);
    end
    in_valid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      do_load(vecs[i].seed);
      check("table_after_load_in_ready", in_ready, 1'b1);
      send_word(vecs[i].cipher, 0);
      check("table_msg", out_msg, vecs[i].msg);
      consume(0);
    end

    // Backpressure: beats offered during HOLD must not be consumed.
    do_load(32'hABCDEF01);
    send_word(32'hAACFEA0A, 0);
    in_valid = 1'b1; in_data = 8'h55;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_msg", out_msg, 32'hABCDEF01);
      check("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    consume(0);
    send_word(32'h12345678, 0);
    consume(2);

    // Gapped input yields the same plaintext.
    do_load(32'hABCDEF01);
    send_word(32'hAACFEA0A, 3);
    check("gapped_msg", out_msg, 32'hABCDEF01);
    consume(1);

    // Reseed mid-word discards the partial word.
    do_load(32'h13572468);
    send_beat(8'h11);
    send_beat(8'h22);
    check("reseed_busy_before", busy, 1'b1);
    do_load(32'hABCDEF01);
    check("reseed_busy_after", busy, 1'b0);
    check("reseed_word_count", word_count, exp_wc);
    send_word(32'hAACFEA0A, 0);
    check("reseed_msg", out_msg, 32'hABCDEF01);
    consume(0);

    // Reset mid-word.
    do_load(32'hCAFEBABE);
    send_beat(8'h33);
    send_beat(8'h44);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_wc = 16'd0;
    in_valid = 1'b1; in_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mid_in_ready", in_ready, 1'b0);
      check("rst_mid_out_valid", out_valid, 1'b0);
      check("rst_mid_out_msg", out_msg, 32'd0);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_word_count", word_count, 16'd0);
    end
    in_valid = 1'b0;

    // Load together with a beat: the beat is dropped.
    load = 1'b1; seed = 32'hABCDEF01; in_valid = 1'b1; in_data = 8'hAA;
    tick();
    load = 1'b0; in_valid = 1'b0;
    model_load(32'hABCDEF01);
    check("collide_busy", busy, 1'b0);
    send_word(32'hAACFEA0A, 0);
    check("collide_msg", out_msg, 32'hABCDEF01);
    consume(0);

    // Load while holding an unconsumed word, with out_ready in the same cycle.
    do_load(32'h0BADF00D);
    send_word(32'h89ABCDEF, 1);
    load = 1'b1; seed = 32'hABCDEF01; out_ready = 1'b1;
    tick();
    load = 1'b0; out_ready = 1'b0;
    model_load(32'hABCDEF01);
    check("hold_load_out_valid", out_valid, 1'b0);
    check("hold_load_word_count", word_count, exp_wc);
    check("hold_load_in_ready", in_ready, 1'b1);
    send_word(32'hAACFEA0A, 0);
    check("hold_load_msg", out_msg, 32'hABCDEF01);
    consume(0);

    // Randomized words with gaps, backpressure and occasional aborted words.
    for (int i = 0; i < 30; i++) begin
      do_load($urandom);
      if ($urandom_range(0, 3) == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) send_beat(8'($urandom));
        do_load($urandom);
        check("rand_abort_busy", busy, 1'b0);
      end
      for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
        send_word($urandom, int'($urandom_range(0, 2)));
        consume(int'($urandom_range(0, 3)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
